// File: rtl/btn_pkg.sv
// Shared register offsets and legacy code table for the button controller.
package btn_pkg;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_EVENT  = 2'd1;
   localparam logic [1:0] REG_IRQ_EN = 2'd2;
   localparam logic [1:0] REG_CODE   = 2'd3;

   localparam logic [31:0] CODE_B0   = 32'h1111_1111;
   localparam logic [31:0] CODE_B1   = 32'h2222_2222;
   localparam logic [31:0] CODE_B2   = 32'h4444_4444;
   localparam logic [31:0] CODE_B3   = 32'h8888_8888;
   localparam logic [31:0] CODE_B4   = 32'hFFFF_FFFF;
   localparam logic [31:0] CODE_NONE = 32'h0000_0000;

   function automatic logic [31:0] legacy_code(input logic [4:0] s);
      logic [31:0] c;
      case (s)
         5'b00001: c = CODE_B0;
         5'b00010: c = CODE_B1;
         5'b00100: c = CODE_B2;
         5'b01000: c = CODE_B3;
         5'b10000: c = CODE_B4;
         default:  c = CODE_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer followed by a stability counter.
module btn_debounce #(
   parameter int DEB_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic stable,
   output logic rise
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_done;

   assign w_diff = r_s2 ^ r_stable;
   assign w_done = w_diff && (r_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_s1 <= din;
         r_s2 <= r_s1;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // rise is combinational so the register file sets event on the update edge
   assign stable = r_stable;
   assign rise   = w_done & r_s2;

endmodule

// File: rtl/btn_ctrl.sv
// Button controller: per-channel debouncers, event/irq-enable registers,
// legacy code decode and level interrupt.
module btn_ctrl
   import btn_pkg::*;
#(
   parameter int N_BTN      = 5,
   parameter int DEB_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic             we,
   input  logic [31:0]      wdata,
   input  logic [N_BTN-1:0] button,
   output logic [31:0]      rdata,
   output logic             irq
);

   logic [N_BTN-1:0] w_stable;
   logic [N_BTN-1:0] w_rise;
   logic [N_BTN-1:0] r_event;
   logic [N_BTN-1:0] r_irq_en;
   logic [1:0]       w_sel;
   logic [N_BTN-1:0] w_wbits;
   logic             w_unused;

   assign w_sel    = addr[3:2];
   assign w_wbits  = wdata[N_BTN-1:0];
   assign w_unused = &{1'b0, addr[31:4], addr[1:0], wdata};

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk    (clk),
         .rst    (rst),
         .din    (button[i]),
         .stable (w_stable[i]),
         .rise   (w_rise[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_event  <= '0;
         r_irq_en <= '0;
      end else begin
         // a new rising edge overrides a same-cycle clear
         if (we && (w_sel == REG_EVENT))
            r_event <= (r_event & ~w_wbits) | w_rise;
         else
            r_event <= r_event | w_rise;
         if (we && (w_sel == REG_IRQ_EN))
            r_irq_en <= w_wbits;
      end
   end

   always_comb begin
      rdata = '0;
      case (w_sel)
         REG_STATUS: rdata = 32'(w_stable);
         REG_EVENT:  rdata = 32'(r_event);
         REG_IRQ_EN: rdata = 32'(r_irq_en);
         REG_CODE:   rdata = legacy_code(w_stable[4:0]);
         default:    rdata = '0;
      endcase
   end

   assign irq = |(r_event & r_irq_en);

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with a window-based debounce model.
module tb_btn_ctrl;

   localparam int N = 5;
   localparam int D = 4;

   logic          clk;
   logic          rst;
   logic [31:0]   addr;
   logic          we;
   logic [31:0]   wdata;
   logic [N-1:0]  button;
   logic [31:0]   rdata;
   logic          irq;

   int nvec = 0;
   int nerr = 0;

   btn_ctrl #(
      .N_BTN      (N),
      .DEB_CYCLES (D)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .we     (we),
      .wdata  (wdata),
      .button (button),
      .rdata  (rdata),
      .irq    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: hist[0] is the sample taken at the previous edge
   logic [N-1:0] hist [0:D];
   logic [N-1:0] m_stable;
   logic [N-1:0] m_event;
   logic [N-1:0] m_irq_en;
   bit           m_valid = 1'b0;

   function automatic logic [31:0] m_code(input logic [4:0] s);
      logic [31:0] c;
      case (s)
         5'b00001: c = 32'h1111_1111;
         5'b00010: c = 32'h2222_2222;
         5'b00100: c = 32'h4444_4444;
         5'b01000: c = 32'h8888_8888;
         5'b10000: c = 32'hFFFF_FFFF;
         default:  c = 32'h0;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] a);
      logic [31:0] r;
      case (a[3:2])
         2'd0:    r = 32'(m_stable);
         2'd1:    r = 32'(m_event);
         2'd2:    r = 32'(m_irq_en);
         default: r = m_code(m_stable[4:0]);
      endcase
      return r;
   endfunction

   always @(posedge clk) begin : model
      logic [N-1:0] rise_v;
      bit same;
      if (rst) begin
         for (int j = 0; j <= D; j++) hist[j] = '0;
         m_stable = '0;
         m_event  = '0;
         m_irq_en = '0;
         m_valid  = 1'b1;
      end else if (m_valid) begin
         rise_v = '0;
         // accept a level once the last D synchronized samples all agree
         for (int c = 0; c < N; c++) begin
            same = 1'b1;
            for (int j = 2; j <= D; j++)
               if (hist[j][c] != hist[1][c]) same = 1'b0;
            if (same && (hist[1][c] != m_stable[c])) begin
               m_stable[c] = hist[1][c];
               if (hist[1][c]) rise_v[c] = 1'b1;
            end
         end
         if (we && addr[3:2] == 2'd1) m_event = m_event & ~wdata[N-1:0];
         if (we && addr[3:2] == 2'd2) m_irq_en = wdata[N-1:0];
         m_event = m_event | rise_v;
         for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = button;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("rdata", rdata, m_rd(addr));
         chk("irq", {31'b0, irq}, {31'b0, |(m_event & m_irq_en)});
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a,
                         input logic [31:0] exp);
      addr = a;
      #1;
      chk(nm, rdata, exp);
   endtask

   localparam logic [31:0] A_ST = 32'h0;
   localparam logic [31:0] A_EV = 32'h4;
   localparam logic [31:0] A_IE = 32'h8;
   localparam logic [31:0] A_CD = 32'hC;

   initial begin
      rst    = 1'b1;
      we     = 1'b0;
      addr   = '0;
      wdata  = '0;
      button = '0;
      tick(2);
      rst = 1'b0;
      rd_chk("rst_status", A_ST, 32'h0);
      rd_chk("rst_code", A_CD, 32'h0);
      rd_chk("rst_event", A_EV, 32'h0);
      rd_chk("rst_irqen", A_IE, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);

      // single press: accepted on edge k+5
      button = 5'b00001;
      tick(5);
      rd_chk("b0_code_early", A_CD, 32'h0);
      rd_chk("b0_status_early", A_ST, 32'h0);
      tick();
      rd_chk("b0_code", A_CD, 32'h1111_1111);
      rd_chk("b0_status", A_ST, 32'h1);
      rd_chk("b0_event", A_EV, 32'h1);
      button = '0;
      tick(8);
      rd_chk("b0_rel_status", A_ST, 32'h0);
      rd_chk("b0_rel_event", A_EV, 32'h1);
      wr(A_EV, 32'h1F);
      rd_chk("w1c_all", A_EV, 32'h0);

      // short glitch is rejected
      button = 5'b00100;
      tick(3);
      button = '0;
      tick(8);
      rd_chk("glitch_status", A_ST, 32'h0);
      rd_chk("glitch_event", A_EV, 32'h0);

      // two buttons together
      button = 5'b01001;
      tick(8);
      rd_chk("two_status", A_ST, 32'h09);
      rd_chk("two_code", A_CD, 32'h0);
      rd_chk("two_event", A_EV, 32'h09);
      wr(A_ST, 32'h1F);
      rd_chk("status_ro", A_ST, 32'h09);
      button = '0;
      tick(8);
      wr(A_EV, 32'h1F);

      // interrupt path
      wr(A_IE, 32'hFFFF_FFFF);
      rd_chk("irqen_mask", A_IE, 32'h1F);
      wr(A_IE, 32'h10);
      button = 5'b10000;
      tick(8);
      chk("irq_set", {31'b0, irq}, 32'h1);
      rd_chk("b4_code", A_CD, 32'hFFFF_FFFF);
      wr(A_EV, 32'h10);
      chk("irq_clr", {31'b0, irq}, 32'h0);
      button = '0;
      tick(8);
      chk("irq_rel", {31'b0, irq}, 32'h0);
      button = 5'b10000;
      tick(8);
      chk("irq_again", {31'b0, irq}, 32'h1);
      button = '0;
      tick(8);
      wr(A_EV, 32'h1F);
      wr(A_IE, 32'h0);

      // clear on the acceptance edge: set wins
      button = 5'b00010;
      tick(5);
      wr(A_EV, 32'h2);
      rd_chk("setwin_event", A_EV, 32'h2);
      rd_chk("setwin_code", A_CD, 32'h2222_2222);
      button = '0;
      tick(8);
      wr(A_EV, 32'h1F);

      // reset mid-debounce, with a write in the reset cycle
      wr(A_IE, 32'h08);
      button = 5'b01000;
      tick(4);
      rst   = 1'b1;
      addr  = A_IE;
      wdata = 32'h1F;
      we    = 1'b1;
      tick();
      we  = 1'b0;
      rst = 1'b0;
      rd_chk("rst2_irqen", A_IE, 32'h0);
      rd_chk("rst2_status", A_ST, 32'h0);
      rd_chk("rst2_event", A_EV, 32'h0);
      tick(5);
      rd_chk("rst2_status_early", A_ST, 32'h0);
      tick();
      rd_chk("rst2_status", A_ST, 32'h08);
      rd_chk("rst2_event_after", A_EV, 32'h08);
      chk("rst2_irq", {31'b0, irq}, 32'h0);
      button = '0;
      tick(8);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
